// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic C = A*B engine: DIM x DIM PE grid, run-time size n <= DIM,
// own load/compute/drain sequencer and a saturating valid/ready result stream.
module systolic_matmul_engine #(
  parameter int DIM    = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DIM+1)-1:0] size,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);
  localparam int SZ_W  = $clog2(DIM+1);
  localparam int IDX_W = $clog2(DIM);
  localparam int T_W   = $clog2(3*DIM);
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;
  state_t r_state, w_state_next;

  logic [SZ_W-1:0]  r_n;
  logic [SZ_W-1:0]  w_size_clamped;
  logic [IDX_W-1:0] w_n_m1;
  logic [T_W-1:0]   w_n_t;
  logic [T_W-1:0]   w_step_max;

  logic [IDX_W-1:0] r_ld_row, r_ld_col;
  logic             r_ld_b;
  logic [T_W-1:0]   r_step;
  logic [IDX_W-1:0] r_out_row, r_out_col;
  logic [IDX_W-1:0] w_out_row_next, w_out_col_next;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_last;
  logic             r_done;
  logic             w_load_fire, w_load_last, w_step_last, w_out_fire;

  logic [DATA_W-1:0] r_mem_a [DIM][DIM];
  logic [DATA_W-1:0] r_mem_b [DIM][DIM];
  logic [DATA_W-1:0] w_a_feed [DIM];
  logic [DATA_W-1:0] w_b_feed [DIM];
  logic [DATA_W-1:0] w_a_in [DIM][DIM];
  logic [DATA_W-1:0] w_b_in [DIM][DIM];
  logic [DATA_W-1:0] r_a_pass [DIM][DIM-1];
  logic [DATA_W-1:0] r_b_pass [DIM-1][DIM];
  logic [ACC_W-1:0]  r_acc [DIM][DIM];
  logic [ACC_W-1:0]  w_acc_next [DIM][DIM];

  function automatic logic [OUT_W-1:0] f_sat(input logic [ACC_W-1:0] v);
    return (v > SAT_MAX) ? {OUT_W{1'b1}} : v[OUT_W-1:0];
  endfunction

  assign w_size_clamped = (size == '0 || size > SZ_W'(DIM)) ? SZ_W'(DIM) : size;
  assign w_n_m1     = IDX_W'(r_n - SZ_W'(1));
  assign w_n_t      = T_W'(r_n);
  assign w_step_max = (w_n_t << 1) + w_n_t - T_W'(3);

  assign w_load_fire = (r_state == S_LOAD) && load_valid;
  assign w_load_last = w_load_fire && r_ld_b && (r_ld_row == w_n_m1) && (r_ld_col == w_n_m1);
  assign w_step_last = (r_state == S_COMPUTE) && (r_step == w_step_max);
  assign w_out_fire  = (r_state == S_DRAIN) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_LOAD;
      S_LOAD:    if (w_load_last) w_state_next = S_COMPUTE;
      S_COMPUTE: if (w_step_last) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_out_fire && r_out_last) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_row_next = r_out_row;
    w_out_col_next = r_out_col + IDX_W'(1);
    if (r_out_col == w_n_m1) begin
      w_out_col_next = '0;
      w_out_row_next = r_out_row + IDX_W'(1);
    end
  end

  // Operand storage is never reset: every job rewrites all 2n^2 words it uses.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      if (r_ld_b) r_mem_b[r_ld_row][r_ld_col] <= load_data;
      else        r_mem_a[r_ld_row][r_ld_col] <= load_data;
    end
  end

  genvar gi, gj;
  generate
    // Edge feeds: row/column gi is skewed by gi, so element k enters at step gi+k.
    for (gi = 0; gi < DIM; gi++) begin : g_feed
      localparam logic [T_W-1:0] OFF = T_W'(gi);
      logic [T_W-1:0] w_k;
      logic           w_feed_ok;
      assign w_k       = r_step - OFF;
      assign w_feed_ok = (r_state == S_COMPUTE) && (r_step >= OFF) && (w_k < w_n_t) && (OFF < w_n_t);
      assign w_a_feed[gi] = w_feed_ok ? r_mem_a[gi][w_k[IDX_W-1:0]] : '0;
      assign w_b_feed[gi] = w_feed_ok ? r_mem_b[w_k[IDX_W-1:0]][gi] : '0;
    end

    for (gi = 0; gi < DIM; gi++) begin : g_row
      for (gj = 0; gj < DIM; gj++) begin : g_col
        logic [2*DATA_W-1:0] w_prod;
        if (gj == 0) begin : g_a_edge
          assign w_a_in[gi][gj] = w_a_feed[gi];
        end else begin : g_a_link
          assign w_a_in[gi][gj] = r_a_pass[gi][gj-1];
        end
        if (gi == 0) begin : g_b_edge
          assign w_b_in[gi][gj] = w_b_feed[gj];
        end else begin : g_b_link
          assign w_b_in[gi][gj] = r_b_pass[gi-1][gj];
        end
        assign w_prod = {{DATA_W{1'b0}}, w_a_in[gi][gj]} * {{DATA_W{1'b0}}, w_b_in[gi][gj]};
        assign w_acc_next[gi][gj] = (r_state == S_COMPUTE) ? r_acc[gi][gj] + ACC_W'(w_prod)
                                                           : r_acc[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= '0;
      r_ld_row   <= '0;
      r_ld_col   <= '0;
      r_ld_b     <= 1'b0;
      r_step     <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) r_acc[i][j] <= '0;
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM-1; j++) r_a_pass[i][j] <= '0;
      for (int i = 0; i < DIM-1; i++)
        for (int j = 0; j < DIM; j++) r_b_pass[i][j] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n      <= w_size_clamped;
            r_ld_row <= '0;
            r_ld_col <= '0;
            r_ld_b   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_load_fire) begin
            if (r_ld_col == w_n_m1) begin
              r_ld_col <= '0;
              if (r_ld_row == w_n_m1) begin
                r_ld_row <= '0;
                r_ld_b   <= 1'b1;
              end else begin
                r_ld_row <= r_ld_row + IDX_W'(1);
              end
            end else begin
              r_ld_col <= r_ld_col + IDX_W'(1);
            end
          end
          if (w_load_last) begin
            r_step <= '0;
            for (int i = 0; i < DIM; i++)
              for (int j = 0; j < DIM; j++) r_acc[i][j] <= '0;
            for (int i = 0; i < DIM; i++)
              for (int j = 0; j < DIM-1; j++) r_a_pass[i][j] <= '0;
            for (int i = 0; i < DIM-1; i++)
              for (int j = 0; j < DIM; j++) r_b_pass[i][j] <= '0;
          end
        end
        S_COMPUTE: begin
          r_step <= r_step + T_W'(1);
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) r_acc[i][j] <= w_acc_next[i][j];
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM-1; j++) r_a_pass[i][j] <= w_a_in[i][j];
          for (int i = 0; i < DIM-1; i++)
            for (int j = 0; j < DIM; j++) r_b_pass[i][j] <= w_b_in[i][j];
          // C[0][0] is taken from the next-state value so n=1 sees its only product.
          if (w_step_last) begin
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_out_data <= f_sat(w_acc_next[0][0]);
            r_out_last <= (w_n_m1 == '0);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (r_out_last) begin
              r_out_last <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_out_row  <= w_out_row_next;
              r_out_col  <= w_out_col_next;
              r_out_data <= f_sat(r_acc[w_out_row_next][w_out_col_next]);
              r_out_last <= (w_out_row_next == w_n_m1) && (w_out_col_next == w_n_m1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign load_ready = (r_state == S_LOAD);
  assign out_valid  = (r_state == S_DRAIN);
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule
